load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory-stage load/store unit between the execute stage and the word-wide data memory.
//  Accepts one byte/half/word load or store per request and drives the memory's
//  mem_addr / wr_data / MemWrite / MemRead. Sub-word stores use read-modify-write.
//  Load data is aligned and sign/zero-extended, then handed to writeback via a valid/ready response.
// PARAMETERS
//  MEM_WORDS  256  data memory depth in 32-bit words; word index = req_addr[2 +: $clog2(MEM_WORDS)]
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  req_valid    in   1   execute stage presents a request
//  req_ready    out  1   high only in IDLE; transfer on req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_funct3   in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; low byte/half is used for SB/SH
//  req_rd       in   5   destination register tag, returned unchanged
//  resp_valid   out  1   response available; held until resp_ready
//  resp_ready   in   1   writeback accepts the response
//  resp_data    out  32  extended load data; 0 for stores and errors
//  resp_rd      out  5   tag of the completed request
//  resp_err     out  1   illegal funct3, or misaligned access (macro-dependent)
//  mem_addr     out  32  word index, zero-extended; 0 when idle
//  mem_wr_data  out  32  word to write
//  mem_write    out  1   write strobe to memory; one cycle per write
//  mem_read     out  1   read strobe; memory returns data registered on the next edge
//  mem_rd_data  in   32  memory read data; valid the cycle after mem_read
// BEHAVIOUR
//  - States: IDLE, RD, CAP, WR, RESP. Request fields are registered on accept.
//  - Reset: go to IDLE. resp_valid, resp_err, mem_write and mem_read = 0;
//    resp_data, resp_rd, mem_addr and mem_wr_data = 0.
//  - Reset mid-operation aborts immediately. No partial write is issued after rst_n falls.
//  - mem_read is high only in RD. mem_write is high only in WR. Both are decoded from state.
//  - Word index wraps modulo MEM_WORDS. Upper address bits are ignored.
//  - LOAD: IDLE -> RD -> CAP -> RESP.
//    - In CAP, select the byte/half by addr[1:0] (big half = addr[1]).
//    - Sign-extend LB/LH; zero-extend LBU/LHU; register the result into resp_data.
//    - resp_valid rises 3 cycles after the accept edge.
//  - SW: IDLE -> WR -> RESP, with mem_wr_data = req_wdata.
//  - SB/SH: IDLE -> RD -> CAP -> WR -> RESP.
//    - In CAP, merge the new byte/half into mem_rd_data at addr[1:0]; write in WR.
//  - RESP: hold all resp_* stable while resp_valid & !resp_ready.
//    On handshake go to IDLE; req_ready rises the next cycle (no back-to-back bypass).
//  - Illegal funct3 (load 3/6/7, store >= 3): IDLE -> RESP, resp_err = 1, no memory strobe.
//  - mem_addr and mem_wr_data are held from RD through WR, so the RMW targets one word.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   - Misaligned access (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0)
//     goes IDLE -> RESP with resp_err = 1, resp_data = 0, and no memory strobe.
//  LSU_MISALIGN_TRAP_EN undefined:
//   - The offending low address bits are forced to 0 and the access completes normally.
//   - resp_err is driven only by illegal funct3.
// STRUCTURE
//  - riscv_pkg: funct3 constants (F3_LB..F3_SW), lsu_state_t enum,
//    and the function mem_word_idx(addr).
//  - Sub-module lsu_load_align (combinational): funct3, addr[1:0], word -> extended 32-bit load data.
//  - The store-merge logic stays local.
// TESTING
//  1. LW addr 0x10, mem[4] = 0xDEADBEEF -> mem_read in cycle 1; resp_valid cycle 3,
//     resp_data 0xDEADBEEF, resp_rd tag echoed.
//  2. LB addr 0x13 / LBU addr 0x13 on word 0x80FF7F01 -> 0xFFFFFF80 / 0x00000080;
//     LH addr 0x12 -> 0xFFFF80FF.
//  3. SB 0xAA to addr 0x21 on word 0x11223344 -> one mem_read, then one mem_write of
//     0x1122AA44 at index 8; neighbouring bytes unchanged.
//  4. resp_ready held low 4 cycles after a load -> resp_* stable,
//     req_ready low, no further mem strobes.
//  5. LW addr 0x06: with LSU_MISALIGN_TRAP_EN -> resp_err = 1, no strobe;
//     without -> reads word 1, resp_err = 0. funct3 = 3'b111 -> resp_err = 1 in both builds.
//  6. rst_n asserted during WR of an SH -> mem_write drops asynchronously,
//     state IDLE, resp_valid = 0, req_ready = 1 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state encoding and
// the byte-address to word-index helper used by the load/store unit.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_t;

    // Word index of a byte address, wrapped to the memory depth (idx_bits wide).
    function automatic logic [31:0] mem_word_idx(input logic [31:0] addr,
                                                 input int unsigned idx_bits);
        logic [31:0] mask_v;
        mask_v = (32'd1 << idx_bits) - 32'd1;
        return {2'b00, addr[31:2]} & mask_v;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the byte/half addressed by off out of the
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane and half lane selection
    always_comb begin
        byte_s = word[7:0];
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extension by load type; unknown codes yield zero
    always_comb begin
        data = 32'd0;
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LW:   data = word;
            F3_LBU:  data = {24'd0, byte_s};
            F3_LHU:  data = {16'd0, half_s};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit with read-modify-write sub-word stores.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rd_data
);

    localparam int unsigned IDX_BITS = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    lsu_state_t  state_r;
    lsu_state_t  state_next_s;

    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic [15:0] wdata_r;
    logic [4:0]  resp_rd_r;
    logic [31:0] resp_data_r;
    logic        resp_err_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wr_data_r;

    logic        illegal_s;
    logic        err_s;
    logic        is_half_s;
    logic        is_word_s;
    logic [1:0]  off_s;
    logic [31:0] merge_s;
    logic [31:0] load_data_s;

    // Request decode: legality, access size and effective byte offset
    always_comb begin
        is_word_s = (req_funct3 == F3_LW);
        is_half_s = (req_funct3 == F3_LH) || (req_funct3 == F3_LHU);
        if (req_we) begin
            illegal_s = (req_funct3 >= 3'd3);
        end else begin
            illegal_s = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
        // Offending low bits are dropped so an untrapped access aligns down
        if (is_word_s) begin
            off_s = 2'b00;
        end else if (is_half_s) begin
            off_s = {req_addr[1], 1'b0};
        end else begin
            off_s = req_addr[1:0];
        end
`ifdef LSU_MISALIGN_TRAP_EN
        err_s = illegal_s
              || (is_half_s && req_addr[0])
              || (is_word_s && (req_addr[1:0] != 2'b00));
`else
        err_s = illegal_s;
`endif
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_valid) begin
                    state_next_s = ST_IDLE;
                end else if (err_s) begin
                    state_next_s = ST_RESP;
                end else if (req_we && (req_funct3 == F3_SW)) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_RD:   state_next_s = ST_CAP;
            ST_CAP: begin
                if (we_r) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_WR:   state_next_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Store merge: new byte/half spliced into the word just read
    always_comb begin
        merge_s = mem_rd_data;
        if (funct3_r == F3_SB) begin
            case (off_r)
                2'd0:    merge_s[7:0]   = wdata_r[7:0];
                2'd1:    merge_s[15:8]  = wdata_r[7:0];
                2'd2:    merge_s[23:16] = wdata_r[7:0];
                2'd3:    merge_s[31:24] = wdata_r[7:0];
                default: merge_s = mem_rd_data;
            endcase
        end else if (funct3_r == F3_SH) begin
            if (off_r[1]) begin
                merge_s[31:16] = wdata_r;
            end else begin
                merge_s[15:0] = wdata_r;
            end
        end else begin
            merge_s = mem_rd_data;
        end
    end

    lsu_load_align u_load_align (
        .funct3 (funct3_r),
        .off    (off_r),
        .word   (mem_rd_data),
        .data   (load_data_s)
    );

    // Request capture, memory address/data and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r          <= 1'b0;
            funct3_r      <= 3'd0;
            off_r         <= 2'd0;
            wdata_r       <= 16'd0;
            resp_rd_r     <= 5'd0;
            resp_data_r   <= 32'd0;
            resp_err_r    <= 1'b0;
            mem_addr_r    <= 32'd0;
            mem_wr_data_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        funct3_r    <= req_funct3;
                        off_r       <= off_s;
                        wdata_r     <= req_wdata[15:0];
                        resp_rd_r   <= req_rd;
                        resp_data_r <= 32'd0;
                        resp_err_r  <= err_s;
                        if (err_s) begin
                            mem_addr_r    <= 32'd0;
                            mem_wr_data_r <= 32'd0;
                        end else begin
                            mem_addr_r    <= mem_word_idx(req_addr, IDX_BITS);
                            mem_wr_data_r <= (req_we && (req_funct3 == F3_SW)) ? req_wdata : 32'd0;
                        end
                    end else begin
                        mem_addr_r <= 32'd0;
                    end
                end
                ST_CAP: begin
                    if (we_r) begin
                        mem_wr_data_r <= merge_s;
                    end else begin
                        resp_data_r   <= load_data_s;
                        mem_addr_r    <= 32'd0;
                    end
                end
                ST_WR: begin
                    mem_addr_r    <= 32'd0;
                    mem_wr_data_r <= 32'd0;
                end
                default: begin
                    mem_addr_r <= mem_addr_r;
                end
            endcase
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign resp_valid  = (state_r == ST_RESP);
    assign mem_read    = (state_r == ST_RD);
    assign mem_write   = (state_r == ST_WR);
    assign resp_data   = resp_data_r;
    assign resp_rd     = resp_rd_r;
    assign resp_err    = resp_err_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wr_data = mem_wr_data_r;

endmodule
